// File: rtl/uart_alu_sequencer_if.sv
// Signal bundle between the UART-ALU sequencer and its RX/TX/ALU neighbours.
// slave is the sequencer's view; master is the view of whatever drives it.
interface uart_alu_sequencer_if #(
    parameter int unsigned DBIT = 8,
    parameter int unsigned OPW  = 6
) ();
    logic            i_s_tick;
    logic [DBIT-1:0] i_rx_data;
    logic            i_rx_done;
    logic            i_tx_done;
    logic [DBIT-1:0] i_alu_result;
    logic [DBIT-1:0] o_alu_a;
    logic [DBIT-1:0] o_alu_b;
    logic [OPW-1:0]  o_alu_op;
    logic [DBIT-1:0] o_tx_data;
    logic            o_tx_start;
    logic            o_busy;
    logic            o_frame_err;
    logic            o_op_err;
    logic            o_overrun;

    modport slave (
        input  i_s_tick, i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy,
               o_frame_err, o_op_err, o_overrun
    );

    modport master (
        output i_s_tick, i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy,
               o_frame_err, o_op_err, o_overrun
    );
endinterface

// File: rtl/uart_alu_sequencer.sv
// Collects an A/B/opcode frame from the UART receiver, lets the ALU settle for one
// cycle, then launches a single transmission of the result byte.
module uart_alu_sequencer #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned OPW      = 6,
    parameter int unsigned TO_TICKS = 2560,
    parameter int unsigned TO_W     = 12
) (
    input logic                 i_clock,
    input logic                 i_reset,
    uart_alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {StWaitA, StWaitB, StWaitOp, StExec, StSend, StWaitTx} state_e;

    localparam logic [OPW-1:0]  OpAdd  = OPW'(32'h20);
    localparam logic [OPW-1:0]  OpSub  = OPW'(32'h22);
    localparam logic [OPW-1:0]  OpAnd  = OPW'(32'h24);
    localparam logic [OPW-1:0]  OpOr   = OPW'(32'h25);
    localparam logic [OPW-1:0]  OpXor  = OPW'(32'h26);
    localparam logic [OPW-1:0]  OpNor  = OPW'(32'h27);
    localparam logic [OPW-1:0]  OpSra  = OPW'(32'h03);
    localparam logic [OPW-1:0]  OpSrl  = OPW'(32'h02);
    localparam logic [TO_W-1:0] ToLast = TO_W'(TO_TICKS - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [DBIT-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
    logic [OPW-1:0]  op_q, op_d;
    logic            tx_start_q, tx_start_d, busy_q, busy_d;
    logic            frame_err_q, frame_err_d, op_err_q, op_err_d, overrun_q, overrun_d;

    logic [OPW-1:0]  op_field;
    logic            op_legal;

    assign op_field = bus.i_rx_data[OPW-1:0];
    assign op_legal = (bus.i_rx_data[DBIT-1:OPW] == '0) &&
                      (op_field inside {OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        frame_err_d = 1'b0;
        op_err_d    = 1'b0;
        // Bytes arriving while busy are never consumed by any state.
        overrun_d   = bus.i_rx_done && busy_q;

        unique case (state_q)
            StWaitA: begin
                cnt_d = '0;
                if (bus.i_rx_done) begin
                    a_d     = bus.i_rx_data;
                    state_d = StWaitB;
                end
            end
            StWaitB, StWaitOp: begin
                // A byte on the terminal tick still counts: rx_done is checked first.
                if (bus.i_rx_done) begin
                    cnt_d = '0;
                    if (state_q == StWaitB) begin
                        b_d     = bus.i_rx_data;
                        state_d = StWaitOp;
                    end else if (op_legal) begin
                        op_d    = op_field;
                        state_d = StExec;
                    end else begin
                        op_err_d = 1'b1;
                        state_d  = StWaitA;
                    end
                end else if (bus.i_s_tick) begin
                    if (cnt_q == ToLast) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StWaitA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StExec: begin
                cnt_d      = '0;
                tx_data_d  = bus.i_alu_result;
                tx_start_d = 1'b1;
                state_d    = StSend;
            end
            StSend: begin
                cnt_d   = '0;
                state_d = StWaitTx;
            end
            StWaitTx: begin
                cnt_d = '0;
                if (bus.i_tx_done) begin
                    state_d = StWaitA;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StWaitA;
            end
        endcase

        busy_d = state_d inside {StExec, StSend, StWaitTx};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= StWaitA;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            op_err_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            op_err_q    <= op_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.o_alu_a     = a_q;
    assign bus.o_alu_b     = b_q;
    assign bus.o_alu_op    = op_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_op_err    = op_err_q;
    assign bus.o_overrun   = overrun_q;
endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Controller between the UART receiver/transmitter and the combinational ALU inside the UART-ALU top.
- Collects a 3-byte frame from RX_Uart: operand A, operand B, opcode.
- Presents the frame to the ALU, captures the result, and launches one TX_Uart transmission of the result byte.
- Guards the frame with an inter-byte timeout, opcode validation and overrun detection.

Parameters:
DBIT, 8, data/operand/result width in bits
OPW, 6, opcode width; opcode is byte[OPW-1:0]
TO_TICKS, 2560, baud ticks (i_s_tick pulses) allowed between frame bytes before abort
TO_W, 12, timeout counter width; must satisfy 2^TO_W > TO_TICKS

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_s_tick  in  1  baud-rate tick from Baud_rate_generator, one-cycle pulse
i_rx_data  in  DBIT  byte from RX_Uart, valid when i_rx_done=1
i_rx_done  in  1  RX byte-complete pulse
i_tx_done  in  1  TX_Uart transmit-complete pulse
i_alu_result  in  DBIT  combinational ALU output
o_alu_a  out  DBIT  operand A register
o_alu_b  out  DBIT  operand B register
o_alu_op  out  OPW  opcode register
o_tx_data  out  DBIT  result byte to TX_Uart
o_tx_start  out  1  TX start, one-cycle pulse
o_busy  out  1  high from EXEC through WAIT_TX
o_frame_err  out  1  one-cycle pulse: timeout abort
o_op_err  out  1  one-cycle pulse: illegal opcode, frame dropped
o_overrun  out  1  one-cycle pulse: byte received while busy, byte dropped

Behaviour:
Reset:
- Synchronous. State = WAIT_A; all data outputs 0; all pulses and o_busy 0; timeout counter 0.
- Reset asserted mid-frame or mid-transmission aborts immediately; no o_tx_start after reset.

Legal opcodes:
- 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA, 0x02 SRL.
- Opcode compare uses byte[OPW-1:0]; byte[DBIT-1:OPW] must be 0, otherwise the opcode is illegal.

State machine (all outputs registered):
- WAIT_A: on i_rx_done, o_alu_a <= i_rx_data; clear timeout counter; go to WAIT_B.
- WAIT_B: on i_rx_done, o_alu_b <= i_rx_data; clear counter; go to WAIT_OP.
- WAIT_OP:
  - On i_rx_done with a legal opcode: o_alu_op <= byte[OPW-1:0]; go to EXEC.
  - On i_rx_done with an illegal opcode: pulse o_op_err; go to WAIT_A; o_alu_op unchanged.
- Timeout (WAIT_B, WAIT_OP):
  - Counter increments on each i_s_tick.
  - When the counter reaches TO_TICKS-1 and another i_s_tick arrives with no i_rx_done: pulse o_frame_err, clear counter, go to WAIT_A. o_alu_a/o_alu_b keep their stale values.
  - If i_rx_done and the terminal tick occur in the same cycle, i_rx_done wins (no error).
  - The counter is held at 0 in WAIT_A, EXEC, SEND and WAIT_TX.
- EXEC: exactly 1 cycle for ALU settle; o_tx_data <= i_alu_result; go to SEND.
- SEND: o_tx_start = 1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold until i_tx_done, then go to WAIT_A.
  - i_tx_done in any other state is ignored.
  - There is no TX timeout.

Latency:
- Opcode i_rx_done in cycle N: EXEC in N+1, o_tx_data valid and o_tx_start=1 in N+2.

Busy and overrun:
- o_busy = 1 in EXEC, SEND and WAIT_TX.
- i_rx_done while o_busy=1: byte discarded, o_overrun pulses in the next cycle, state unaffected.

Operand and opcode stability:
- o_alu_a, o_alu_b and o_alu_op change only on capture.
- o_tx_data changes only in EXEC.
- All are stable throughout a transmission.

Test Plan:
- Nominal ADD: RX bytes 0x14, 0x07, 0x20 -> o_alu_a=0x14, o_alu_b=0x07, o_alu_op=0x20; o_tx_start pulse 2 cycles after the third i_rx_done with o_tx_data=0x1B (ALU model feeding i_alu_result); return to WAIT_A after i_tx_done.
- Back-to-back frames: SUB 0x14,0x07,0x22 then AND 0xF0,0x3C,0x24 -> two transmissions 0x0D then 0x30; second frame's bytes accepted only after the first i_tx_done.
- Illegal opcode: 0x14, 0x07, 0x21 -> o_op_err single pulse, no o_tx_start; next frame 0x01,0x01,0x20 -> transmits 0x02.
- Timeout: 0x14, then silence for TO_TICKS ticks -> o_frame_err pulse on tick TO_TICKS, state WAIT_A; then 0x05,0x03,0x26 -> transmits 0x06. Same test with a byte arriving on the exact terminal tick -> no error.
- Overrun: extra i_rx_done during WAIT_TX -> o_overrun pulse, o_tx_data unchanged, next frame decodes from the following byte as A.
- Reset mid-frame: after 0x14, 0x07, assert i_reset 1 cycle -> all outputs 0, WAIT_A; the subsequent 3-byte frame is processed correctly.
